// File: rtl/tmept_pkg.sv
// Shared TMEPT CPU fetch-path definitions: bus widths, reset PC and the queue entry type.
package tmept_pkg;

  localparam int unsigned TMEPT_ADDR_W = 16;
  localparam int unsigned TMEPT_DATA_W = 8;

  localparam logic [TMEPT_ADDR_W-1:0] TMEPT_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [TMEPT_ADDR_W-1:0] addr;
    logic [TMEPT_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular FIFO of fetch entries with synchronous flush; pops one entry, or two when
// IFQ_PEEK_EN is defined and pop2 accompanies pop.
module ifq_fifo
  import tmept_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
`ifdef IFQ_PEEK_EN
  input  logic                    pop2,
  output logic [TMEPT_DATA_W-1:0] data1,
`endif
  input  fetch_entry_t            wdata,
  output fetch_entry_t            rdata0,
  output logic [CW-1:0]           count
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pop_n;
  fetch_entry_t  mem_q [DEPTH];

  always_comb begin
    pop_n = {{(CW-1){1'b0}}, pop};
`ifdef IFQ_PEEK_EN
    if (pop && pop2) pop_n = CW'(2);
`endif
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - pop_n;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the top masks the head outputs whenever the count says empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata0 = mem_q[rd_ptr_q];
  assign count  = count_q;
`ifdef IFQ_PEEK_EN
  assign data1 = mem_q[rd_ptr_q + PW'(1)].data;
`endif

endmodule

// File: rtl/ifetch_queue.sv
// TMEPT instruction prefetch queue: fetches one ROM byte per cycle into ifq_fifo, flushes on
// redirect. Define IFQ_PEEK_EN to expose the second entry and allow two-entry consumption.
module ifetch_queue
  import tmept_pkg::*;
#(
  parameter int unsigned             DEPTH    = 4,
  parameter logic [TMEPT_ADDR_W-1:0] RESET_PC = TMEPT_RESET_PC,
  localparam int unsigned            CW       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [TMEPT_ADDR_W-1:0] imem_addr,
  input  logic [TMEPT_DATA_W-1:0] imem_data,
  input  logic                    redirect_valid,
  input  logic [TMEPT_ADDR_W-1:0] redirect_pc,
  output logic                    out_valid,
  output logic [TMEPT_DATA_W-1:0] out_byte,
  output logic [TMEPT_ADDR_W-1:0] out_pc,
  input  logic                    out_ready,
`ifdef IFQ_PEEK_EN
  output logic                    out_valid1,
  output logic [TMEPT_DATA_W-1:0] out_byte1,
  input  logic                    in_pop2,
`endif
  output logic [CW-1:0]           level
);

  logic [TMEPT_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic                    push, pop, full;
  logic [CW-1:0]           count;
  fetch_entry_t            wdata, head0;
`ifdef IFQ_PEEK_EN
  logic                    pop2;
  logic [TMEPT_DATA_W-1:0] data1;
`endif

  always_comb begin
    out_valid = (count != '0);
    full      = (count == CW'(DEPTH));
    // Redirect blocks both sides: the head is not consumed and the ROM byte is dropped.
    pop       = out_valid & out_ready & ~redirect_valid;
    push      = ~redirect_valid & (~full | pop);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc;
    else if (push)      fetch_pc_d = fetch_pc_q + 16'd1;

    out_byte = out_valid ? head0.data : '0;
    out_pc   = out_valid ? head0.addr : '0;
`ifdef IFQ_PEEK_EN
    out_valid1 = (count >= CW'(2));
    pop2       = pop & in_pop2 & out_valid1;
    out_byte1  = out_valid1 ? data1 : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_pc_q <= RESET_PC;
    else        fetch_pc_q <= fetch_pc_d;
  end

  assign imem_addr  = fetch_pc_q;
  assign wdata.addr = fetch_pc_q;
  assign wdata.data = imem_data;
  assign level      = count;

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
`ifdef IFQ_PEEK_EN
    .pop2  (pop2),
    .data1 (data1),
`endif
    .wdata (wdata),
    .rdata0(head0),
    .count (count)
  );

endmodule
